// File: rtl/if_stage.sv
// rtl/if_stage.sv - RISC-V instruction-fetch stage with IF/ID register (optional IF_MISALIGN_CHECK_EN)
module if_stage #(
    parameter int unsigned          NB_DATA    = 32,
    parameter int unsigned          NB_PC      = 32,
    parameter logic [NB_PC-1:0]     RESET_PC   = '0,
    parameter logic [NB_DATA-1:0]   NOP_INSTR  = 32'h00000013,
    parameter logic [NB_DATA-1:0]   HALT_INSTR = 32'hFFFFFFFF
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_en,
    input  logic                i_stall,
    input  logic [1:0]          i_pcSrc,
    input  logic                i_flush,
    input  logic [NB_PC-1:0]    i_branch_target,
    input  logic [NB_PC-1:0]    i_jalr_target,
    input  logic [NB_DATA-1:0]  i_imem_data,
    output logic [NB_PC-1:0]    o_imem_addr,
    output logic [NB_PC-1:0]    o_pc,
    output logic [NB_PC-1:0]    o_pc4,
    output logic [NB_DATA-1:0]  o_instr,
    output logic                o_valid,
    output logic                o_halted,
    output logic                o_misaligned
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t             state;
    logic [NB_PC-1:0]   pc_q;
    logic [NB_PC-1:0]   pc_plus4;
    logic [NB_PC-1:0]   flush_target;

    // Fetch address is the PC flop itself, no logic in between
    assign o_imem_addr = pc_q;

    // Redirect target selection; reserved pcSrc falls back to sequential fetch
    always_comb begin
        pc_plus4     = pc_q + NB_PC'(4);
        flush_target = pc_plus4;
        case (i_pcSrc)
            2'b01:   flush_target = i_branch_target;
            2'b10:   flush_target = {i_jalr_target[NB_PC-1:1], 1'b0};
            default: flush_target = pc_plus4;
        endcase
    end

`ifndef IF_MISALIGN_CHECK_EN
    assign o_misaligned = 1'b0;
`endif

    // PC, IF/ID register and fetch FSM; enable freezes everything, then flush, stall, state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_BOOT;
            pc_q     <= RESET_PC;
            o_pc     <= '0;
            o_pc4    <= '0;
            o_instr  <= NOP_INSTR;
            o_valid  <= 1'b0;
            o_halted <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
            o_misaligned <= 1'b0;
`endif
        end else if (i_en) begin
            if (i_flush) begin
                pc_q    <= flush_target;
                o_pc    <= '0;
                o_pc4   <= '0;
                o_instr <= NOP_INSTR;
                o_valid <= 1'b0;
`ifdef IF_MISALIGN_CHECK_EN
                // A misaligned redirect is fatal: park in HALT until reset
                if (o_misaligned || (flush_target[1:0] != 2'b00)) begin
                    o_misaligned <= 1'b1;
                    state        <= ST_HALT;
                    o_halted     <= 1'b1;
                end else begin
                    state    <= ST_RUN;
                    o_halted <= 1'b0;
                end
`else
                state    <= ST_RUN;
                o_halted <= 1'b0;
`endif
            end else if (!i_stall) begin
                case (state)
                    ST_RUN: begin
                        o_pc    <= pc_q;
                        o_pc4   <= pc_plus4;
                        o_instr <= i_imem_data;
                        o_valid <= 1'b1;
                        // HALT still drains downstream; only the PC stops
                        if (i_imem_data == HALT_INSTR) begin
                            state    <= ST_HALT;
                            o_halted <= 1'b1;
                        end else begin
                            pc_q <= pc_plus4;
                        end
                    end
                    default: begin
                        o_pc    <= '0;
                        o_pc4   <= '0;
                        o_instr <= NOP_INSTR;
                        o_valid <= 1'b0;
                        if (state == ST_BOOT) begin
                            state <= ST_RUN;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard testbench for if_stage
module tb_if_stage;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        i_clk;
    logic        i_rst_n;
    logic        i_en;
    logic        i_stall;
    logic [1:0]  i_pcSrc;
    logic        i_flush;
    logic [31:0] i_branch_target;
    logic [31:0] i_jalr_target;
    logic [31:0] i_imem_data;
    logic [31:0] o_imem_addr;
    logic [31:0] o_pc;
    logic [31:0] o_pc4;
    logic [31:0] o_instr;
    logic        o_valid;
    logic        o_halted;
    logic        o_misaligned;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
        logic        valid;
        logic        halted;
        logic        mis;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks;
    int   n_fail;
    int   cyc;

    if_stage dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_en            (i_en),
        .i_stall         (i_stall),
        .i_pcSrc         (i_pcSrc),
        .i_flush         (i_flush),
        .i_branch_target (i_branch_target),
        .i_jalr_target   (i_jalr_target),
        .i_imem_data     (i_imem_data),
        .o_imem_addr     (o_imem_addr),
        .o_pc            (o_pc),
        .o_pc4           (o_pc4),
        .o_instr         (o_instr),
        .o_valid         (o_valid),
        .o_halted        (o_halted),
        .o_misaligned    (o_misaligned)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Instruction memory: HALT at 0xC, otherwise an addi tagged with the address
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        if (a == 32'h0000000C) return HALT;
        return {a[11:0], 20'h00093};
    endfunction

    always_comb i_imem_data = imem_word(o_imem_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] addr, input logic [31:0] pc,
                                input logic [31:0] pc4, input logic [31:0] instr,
                                input logic valid, input logic halted, input logic mis);
        exp_t e;
        e.addr = addr; e.pc = pc; e.pc4 = pc4; e.instr = instr;
        e.valid = valid; e.halted = halted; e.mis = mis;
        return e;
    endfunction

    function automatic exp_t bub(input logic [31:0] addr, input logic halted, input logic mis);
        return mk(addr, 32'h0, 32'h0, NOP, 1'b0, halted, mis);
    endfunction

    task automatic compare_head(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        check({tag, "_addr"},   o_imem_addr,  e.addr);
        check({tag, "_pc"},     o_pc,         e.pc);
        check({tag, "_pc4"},    o_pc4,        e.pc4);
        check({tag, "_instr"},  o_instr,      e.instr);
        check({tag, "_valid"},  {31'd0, o_valid},      {31'd0, e.valid});
        check({tag, "_halted"}, {31'd0, o_halted},     {31'd0, e.halted});
        check({tag, "_mis"},    {31'd0, o_misaligned}, {31'd0, e.mis});
    endtask

    // Drive one cycle of stimulus, queue its expected IF/ID state, compare after the edge
    task automatic step(input logic en, input logic stall, input logic flush,
                        input logic [1:0] src, input logic [31:0] bt, input logic [31:0] jt,
                        input exp_t e);
        i_en = en; i_stall = stall; i_flush = flush; i_pcSrc = src;
        i_branch_target = bt; i_jalr_target = jt;
        exp_q.push_back(e);
        @(posedge i_clk);
        #1;
        cyc++;
        compare_head($sformatf("c%0d", cyc));
    endtask

    initial begin
        n_checks = 0; n_fail = 0; cyc = 0;
        i_rst_n = 1'b0; i_en = 1'b0; i_stall = 1'b0; i_flush = 1'b0; i_pcSrc = 2'b00;
        i_branch_target = '0; i_jalr_target = '0;
        #12;
        exp_q.push_back(bub(32'h0, 1'b0, 1'b0));
        compare_head("reset");
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;

        // Boot bubble then sequential fetch
        step(1, 0, 0, 2'b00, 0, 0, bub(32'h0, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h4, 32'h0, 32'h4, imem_word(32'h0), 1, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h8, 32'h4, 32'h8, imem_word(32'h4), 1, 0, 0));
        // Stall twice at PC=8, then disabled flush changes nothing
        step(1, 1, 0, 2'b00, 0, 0, mk(32'h8, 32'h4, 32'h8, imem_word(32'h4), 1, 0, 0));
        step(1, 1, 0, 2'b00, 0, 0, mk(32'h8, 32'h4, 32'h8, imem_word(32'h4), 1, 0, 0));
        step(0, 0, 1, 2'b01, 32'h40, 0, mk(32'h8, 32'h4, 32'h8, imem_word(32'h4), 1, 0, 0));
        // JALR with flush and stall together: flush wins, bit0 cleared
        step(1, 1, 1, 2'b10, 0, 32'h101, bub(32'h100, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h104, 32'h100, 32'h104, imem_word(32'h100), 1, 0, 0));
        // Branch to 0x10, then from PC=0x10 branch to 0x40
        step(1, 0, 1, 2'b01, 32'h10, 0, bub(32'h10, 0, 0));
        step(1, 0, 1, 2'b01, 32'h40, 0, bub(32'h40, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h44, 32'h40, 32'h44, imem_word(32'h40), 1, 0, 0));
        // Flush with pcSrc 00 and reserved 11: sequential redirect plus bubble
        step(1, 0, 1, 2'b00, 32'h99, 32'h99, bub(32'h48, 0, 0));
        step(1, 0, 1, 2'b11, 32'h99, 32'h99, bub(32'h4C, 0, 0));
        // Run into HALT at 0xC
        step(1, 0, 1, 2'b01, 32'h8, 0, bub(32'h8, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'hC, 32'h8, 32'hC, imem_word(32'h8), 1, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'hC, 32'hC, 32'h10, HALT, 1, 1, 0));
        step(1, 0, 0, 2'b00, 0, 0, bub(32'hC, 1, 0));
        step(1, 1, 0, 2'b00, 0, 0, bub(32'hC, 1, 0));
        // Flush leaves HALT
        step(1, 0, 1, 2'b01, 32'h20, 0, bub(32'h20, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h24, 32'h20, 32'h24, imem_word(32'h20), 1, 0, 0));
        // PC wrap at the top of the address space
        step(1, 0, 1, 2'b10, 0, 32'hFFFFFFFD, bub(32'hFFFFFFFC, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h0, 32'hFFFFFFFC, 32'h0, imem_word(32'hFFFFFFFC), 1, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h4, 32'h0, 32'h4, imem_word(32'h0), 1, 0, 0));
`ifdef IF_MISALIGN_CHECK_EN
        step(1, 0, 1, 2'b01, 32'h42, 0, bub(32'h42, 1, 1));
        step(1, 0, 1, 2'b01, 32'h20, 0, bub(32'h20, 1, 1));
        step(1, 0, 0, 2'b00, 0, 0, bub(32'h20, 1, 1));
`else
        step(1, 0, 1, 2'b01, 32'h42, 0, bub(32'h42, 0, 0));
        step(1, 0, 1, 2'b01, 32'h20, 0, bub(32'h20, 0, 0));
        step(1, 0, 0, 2'b00, 0, 0, mk(32'h24, 32'h20, 32'h24, imem_word(32'h20), 1, 0, 0));
`endif
        // Asynchronous reset between edges
        #3;
        i_rst_n = 1'b0;
        #1;
        exp_q.push_back(bub(32'h0, 1'b0, 1'b0));
        compare_head("async_rst");
        check("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
